// File: rtl/seg7_4dig_to_bin.sv
// seg7_4dig_to_bin: decodes four active-low 7-segment codes, most significant digit first, into a binary value that saturates at the top of the range.
module seg7_4dig_to_bin #(
    parameter int N = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [0:6]   D1,
    input  logic [0:6]   D2,
    input  logic [0:6]   D3,
    input  logic [0:6]   D4,
    output logic [N-1:0] Q,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         ovf
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    localparam logic [31:0] MAXV = 32'((2 ** N) - 1);
    state_t          state_q, state_d;
    logic [13:0]     acc_q, acc_d, acc_nxt;
    logic [1:0]      idx_q, idx_d;
    logic [3:0][6:0] snap_q, snap_d;
    logic            errf_q, errf_d;
    logic [N-1:0]    q_q, q_d;
    logic            err_q, err_d, ovf_q, ovf_d;
    logic [6:0]      code;
    logic [3:0]      digit;
    logic            bad, sat;
    always_comb begin
        code  = snap_q[idx_q];
        digit = 4'd0;
        bad   = 1'b0;
        case (code)
            7'b0000001: digit = 4'd0;
            7'b1001111: digit = 4'd1;
            7'b0010010: digit = 4'd2;
            7'b0000110: digit = 4'd3;
            7'b1001100: digit = 4'd4;
            7'b0100100: digit = 4'd5;
            7'b0100000: digit = 4'd6;
            7'b0001111: digit = 4'd7;
            7'b0000000: digit = 4'd8;
            7'b0000100: digit = 4'd9;
            7'b1111111: digit = 4'd0;
            default:    bad   = 1'b1;
        endcase
        acc_nxt = acc_q * 14'd10 + 14'(digit);
        sat     = 32'(acc_nxt) > MAXV;
    end
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        errf_d  = errf_q;
        q_d     = q_q;
        err_d   = err_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (start) begin
                snap_d  = {D4, D3, D2, D1};
                acc_d   = '0;
                errf_d  = 1'b0;
                idx_d   = 2'd3;
                state_d = SCAN;
            end
            SCAN: begin
                acc_d  = acc_nxt;
                errf_d = errf_q | bad;
                idx_d  = idx_q - 2'd1;
                // Last digit: publish results on the same edge that folds in D1
                if (idx_q == 2'd0) begin
                    state_d = DONE;
                    q_d     = sat ? N'(MAXV) : N'(acc_nxt);
                    err_d   = errf_q | bad;
                    ovf_d   = sat;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
            snap_q  <= '0;
            errf_q  <= 1'b0;
            q_q     <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            errf_q  <= errf_d;
            q_q     <= q_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end
    assign Q    = q_q;
    assign err  = err_q;
    assign ovf  = ovf_q;
    assign busy = state_q == SCAN;
    assign done = state_q == DONE;
endmodule
